// File: rtl/mmio_gpio_timer.sv
// mmio_gpio_timer
// Word-addressed peripheral on the data-RAM bus. It provides the following:
//   - debounced switch inputs
//   - an LED output register
//   - a 32-bit down-count timer with a level interrupt
//   - a write-1-to-clear status register
// Reads are combinational and zero-wait.
// The SOPC selects data_o whenever hit_o is high.

module mmio_gpio_timer #(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_1000,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000,
    parameter int          SW_W            = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic            we,
    input  logic [31:0]     addr,
    input  logic [31:0]     data_i,
    output logic [31:0]     data_o,
    output logic            hit_o,
    input  logic [SW_W-1:0] switch_on,
    output logic [31:0]     led_out,
    output logic            irq_o
);

    // Word offsets within the 256-byte window (addr[7:2])
    localparam logic [5:0] W_SWITCH = 6'h00;
    localparam logic [5:0] W_LED    = 6'h01;
    localparam logic [5:0] W_CTRL   = 6'h02;
    localparam logic [5:0] W_LOAD   = 6'h03;
    localparam logic [5:0] W_COUNT  = 6'h04;
    localparam logic [5:0] W_STATUS = 6'h05;

    logic [5:0]      word;
    logic            wr_en;
    logic            rd_en;

    logic [SW_W-1:0] sw_s1;
    logic [SW_W-1:0] sw_s2;
    logic [SW_W-1:0] smp_prev;
    logic [SW_W-1:0] sw_deb;
    logic [15:0]     smp_cnt;
    logic            smp_tick;
    logic            sw_update;

    logic [2:0]      ctrl;
    logic [31:0]     load_val;
    logic [31:0]     count;
    logic [31:0]     count_nxt;
    logic            expire_set;
    logic            expired;
    logic            sw_chg;
    logic            load_wr;
    logic            status_wr;
    logic [31:0]     rd_mux;

    // The low address bits select bytes, which this word-only block ignores
    logic            unused_addr;
    assign unused_addr = ^addr[1:0];

    assign hit_o     = ce & (addr[31:8] == BASE_ADDR[31:8]);
    assign word      = addr[7:2];
    assign wr_en     = hit_o & we;
    assign rd_en     = hit_o & ~we;
    assign load_wr   = wr_en & (word == W_LOAD);
    assign status_wr = wr_en & (word == W_STATUS);

    // Two-flop synchronizer for the raw switch inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= switch_on;
            sw_s2 <= sw_s1;
        end
    end

    assign smp_tick  = (smp_cnt == DEBOUNCE_CYCLES - 16'd1);
    // Two consecutive samples must agree before the debounced value moves.
    // A glitch shorter than one sample period can never appear in both samples.
    assign sw_update = smp_tick & (sw_s2 == smp_prev) & (sw_s2 != sw_deb);

    // Sample counter plus the debounced switch value
    always_ff @(posedge clk) begin
        if (rst) begin
            smp_cnt  <= '0;
            smp_prev <= '0;
            sw_deb   <= '0;
        end else begin
            if (smp_tick) begin
                smp_cnt  <= '0;
                smp_prev <= sw_s2;
            end else begin
                smp_cnt <= smp_cnt + 16'd1;
            end
            if (sw_update)
                sw_deb <= sw_s2;
        end
    end

    // Timer next-state.
    // A LOAD write pre-empts the decrement, including the expiry case.
    always_comb begin
        count_nxt  = count;
        expire_set = 1'b0;
        if (load_wr) begin
            count_nxt = data_i;
        end else if (ctrl[0]) begin
            if (count > 32'd1) begin
                count_nxt = count - 32'd1;
            end else if (count == 32'd1) begin
                expire_set = 1'b1;
                count_nxt  = ctrl[1] ? load_val : 32'd0;
            end
        end
    end

    // Bus-writable registers and the timer counter
    always_ff @(posedge clk) begin
        if (rst) begin
            led_out  <= '0;
            ctrl     <= '0;
            load_val <= '0;
            count    <= '0;
        end else begin
            if (wr_en && word == W_LED)
                led_out <= data_i;
            if (wr_en && word == W_CTRL)
                ctrl <= data_i[2:0];
            if (load_wr)
                load_val <= data_i;
            count <= count_nxt;
        end
    end

    // Status bits. A hardware set wins over a simultaneous write-1-to-clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            expired <= 1'b0;
            sw_chg  <= 1'b0;
        end else begin
            expired <= expire_set | (expired & ~(status_wr & data_i[0]));
            sw_chg  <= sw_update  | (sw_chg  & ~(status_wr & data_i[1]));
        end
    end

    assign irq_o = ctrl[2] & expired;

    // Read mux. Unmapped offsets read as zero.
    always_comb begin
        rd_mux = 32'd0;
        case (word)
            W_SWITCH: rd_mux = {{(32-SW_W){1'b0}}, sw_deb};
            W_LED:    rd_mux = led_out;
            W_CTRL:   rd_mux = {29'd0, ctrl};
            W_LOAD:   rd_mux = load_val;
            W_COUNT:  rd_mux = count;
            W_STATUS: rd_mux = {30'd0, sw_chg, expired};
            default:  rd_mux = 32'd0;
        endcase
    end

    assign data_o = rd_en ? rd_mux : 32'd0;

endmodule

// File: tb/tb_mmio_gpio_timer.sv
// Directed bench for mmio_gpio_timer. Inputs change just after falling edges.
// Outputs are sampled before the next rising edge.

module tb_mmio_gpio_timer;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [15:0] DEB  = 16'd8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        hit_o;
    logic [11:0] switch_on;
    logic [31:0] led_out;
    logic        irq_o;

    int checks   = 0;
    int failures = 0;
    logic [31:0] v;

    mmio_gpio_timer #(
        .BASE_ADDR       (BASE),
        .DEBOUNCE_CYCLES (DEB),
        .SW_W            (12)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .we        (we),
        .addr      (addr),
        .data_i    (data_i),
        .data_o    (data_o),
        .hit_o     (hit_o),
        .switch_on (switch_on),
        .led_out   (led_out),
        .irq_o     (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bus write: it is called just after a falling edge.
    // It returns after the next falling edge, so it consumes exactly one rising edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        ce = 1'b1; we = 1'b1; addr = a; data_i = d;
        @(negedge clk);
        ce = 1'b0; we = 1'b0; data_i = 32'd0;
    endtask

    // Bus read: the combinational value is sampled in the low phase and no clock edge is consumed
    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        ce = 1'b1; we = 1'b0; addr = a;
        #1 d = data_o;
        ce = 1'b0;
    endtask

    initial begin
        ce = 1'b0; we = 1'b0; addr = 32'd0; data_i = 32'd0;
        switch_on = 12'hFFF;
        rst = 1'b1;

        // 1: reset
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_led", led_out, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        rd(BASE + 32'h00, v); check("rst_switch", v, 32'd0);
        switch_on = 12'h3C5;

        // 2: LED register and address decode
        wr(BASE + 32'h04, 32'hA5A5_0F0F);
        check("led_wr", led_out, 32'hA5A5_0F0F);
        rd(BASE + 32'h04, v); check("led_rd", v, 32'hA5A5_0F0F);
        ce = 1'b1; we = 1'b1; addr = BASE + 32'h104; data_i = 32'h1234_5678;
        #1 check("miss_hit", {31'd0, hit_o}, 32'd0);
        @(negedge clk);
        ce = 1'b0; we = 1'b0;
        check("miss_led", led_out, 32'hA5A5_0F0F);
        wr(BASE + 32'h08, 32'hFFFF_FFF8);
        rd(BASE + 32'h08, v); check("ctrl_hi_zero", v, 32'd0);
        rd(BASE + 32'h20, v); check("unmapped_rd", v, 32'd0);

        // 3: debounce and the glitch filter
        repeat (18) @(negedge clk);
        rd(BASE + 32'h00, v); check("sw_stable", v, 32'h3C5);
        rd(BASE + 32'h14, v); check("sw_chg", v, 32'd2);
        switch_on = 12'h000;
        @(negedge clk);
        switch_on = 12'h3C5;
        repeat (20) @(negedge clk);
        rd(BASE + 32'h00, v); check("sw_glitch", v, 32'h3C5);

        // 4: auto-reload with the interrupt enabled
        wr(BASE + 32'h0C, 32'd5);
        wr(BASE + 32'h08, 32'd7);
        rd(BASE + 32'h10, v); check("t4_cnt5", v, 32'd5);
        repeat (4) @(negedge clk);
        rd(BASE + 32'h10, v); check("t4_cnt1", v, 32'd1);
        check("t4_irq_pre", {31'd0, irq_o}, 32'd0);
        @(negedge clk);
        rd(BASE + 32'h10, v); check("t4_reload", v, 32'd5);
        check("t4_irq", {31'd0, irq_o}, 32'd1);
        rd(BASE + 32'h14, v); check("t4_status", v, 32'd3);
        wr(BASE + 32'h14, 32'd1);
        check("t4_irq_clr", {31'd0, irq_o}, 32'd0);
        rd(BASE + 32'h14, v); check("t4_status_clr", v, 32'd2);
        wr(BASE + 32'h08, 32'd0);

        // 5: one-shot with the interrupt disabled
        wr(BASE + 32'h0C, 32'd3);
        wr(BASE + 32'h08, 32'd1);
        rd(BASE + 32'h10, v); check("t5_cnt3", v, 32'd3);
        @(negedge clk);
        rd(BASE + 32'h10, v); check("t5_cnt2", v, 32'd2);
        @(negedge clk);
        rd(BASE + 32'h10, v); check("t5_cnt1", v, 32'd1);
        @(negedge clk);
        rd(BASE + 32'h10, v); check("t5_cnt0", v, 32'd0);
        rd(BASE + 32'h14, v); check("t5_status", v, 32'd3);
        check("t5_irq_off", {31'd0, irq_o}, 32'd0);
        repeat (3) @(negedge clk);
        rd(BASE + 32'h10, v); check("t5_hold0", v, 32'd0);
        wr(BASE + 32'h14, 32'd1);
        repeat (3) @(negedge clk);
        rd(BASE + 32'h14, v); check("t5_once", v, 32'd2);
        wr(BASE + 32'h08, 32'd0);

        // 6: reset in the middle of a count
        wr(BASE + 32'h04, 32'h0000_00FF);
        wr(BASE + 32'h0C, 32'd4);
        wr(BASE + 32'h08, 32'd1);
        repeat (2) @(negedge clk);
        rd(BASE + 32'h10, v); check("t6_cnt2", v, 32'd2);
        check("t6_led", led_out, 32'h0000_00FF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_led_rst", led_out, 32'd0);
        check("t6_irq_rst", {31'd0, irq_o}, 32'd0);
        rd(BASE + 32'h10, v); check("t6_cnt_rst", v, 32'd0);
        rd(BASE + 32'h14, v); check("t6_status_rst", v, 32'd0);
        rd(BASE + 32'h08, v); check("t6_ctrl_rst", v, 32'd0);
        rd(BASE + 32'h0C, v); check("t6_load_rst", v, 32'd0);
        rd(BASE + 32'h00, v); check("t6_sw_rst", v, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
